// File: rtl/ntt_pkg.sv
// ntt_pkg
// Shared constants and helpers for the q = 12289 NTT datapath.
//   Q / Q_INV  : modulus and its Barrett constant floor(2^28 / Q)
//   DATA_W     : coefficient width
//   MULT_LAT   : fixed latency of mod_mult_m_14
//   mode_e     : butterfly flavour (Cooley-Tukey / Gentleman-Sande)
package ntt_pkg;

    localparam int DATA_W   = 14;
    localparam int MULT_LAT = 14;

    localparam logic [DATA_W-1:0] Q     = 14'd12289;
    localparam logic [DATA_W:0]   Q_INV = 15'd21843;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } mode_e;

    // Inputs are already reduced, so one conditional subtract suffices.
    function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q})
            return DATA_W'(s - {1'b0, Q});
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        if (a < b)
            return DATA_W'({1'b0, a} + {1'b0, Q} - {1'b0, b});
        return a - b;
    endfunction

endpackage

// File: rtl/ntt_butterfly_14_if.sv
// ntt_butterfly_14_if
// Operand/result bundle of the butterfly.
//   master : drives in_* operands, observes out_* results and busy
//   slave  : the butterfly itself
interface ntt_butterfly_14_if
    import ntt_pkg::*;
#(
    parameter int TAG_W = 8
) ();
    logic              in_valid;
    logic              in_mode;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DATA_W-1:0] in_w;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_y;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_w, in_tag,
        input  out_valid, out_x, out_y, out_tag, busy
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_w, in_tag,
        output out_valid, out_x, out_y, out_tag, busy
    );
endinterface

// File: rtl/mod_mult_m_14.sv
// mod_mult_m_14
// Pipelined modular multiplier, o_p = i_a * i_b mod i_modulus, fixed
// latency MULT_LAT cycles, one operation per cycle, Barrett reduction.
//   clk, rst       : clock, async active-low reset
//   i_a, i_b       : operands, already reduced
//   i_modulus      : modulus
//   i_modulus_inv  : floor(2^28 / modulus)
//   o_p            : product, valid MULT_LAT edges after the operands
module mod_mult_m_14
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_modulus,
    input  logic [DATA_W:0]   i_modulus_inv,
    output logic [DATA_W-1:0] o_p
);
    localparam int PW  = 2 * DATA_W;
    localparam int QW  = PW + DATA_W + 1;
    localparam int RW  = PW + 1;
    localparam int PAD = MULT_LAT - 4;

    logic [PW-1:0]     r_p1;
    logic [PW-1:0]     r_p2;
    logic [DATA_W:0]   r_qhat;
    logic [15:0]       r_r;
    logic [DATA_W-1:0] r_red;
    logic [DATA_W-1:0] r_dly [PAD];

    logic [15:0]       w_r;
    logic [15:0]       w_1q;
    logic [15:0]       w_2q;
    logic [DATA_W-1:0] w_red;

    // Barrett estimate undershoots the true quotient by at most 2, so the
    // remainder lands in [0, 3q) and needs up to two subtractions.
    always_comb begin
        w_r  = 16'(RW'(r_p2) - RW'(r_qhat) * RW'(i_modulus));
        w_1q = {2'b00, i_modulus};
        w_2q = {1'b0, i_modulus, 1'b0};
        w_red = r_r[DATA_W-1:0];
        if (r_r >= w_2q)
            w_red = DATA_W'(r_r - w_2q);
        else if (r_r >= w_1q)
            w_red = DATA_W'(r_r - w_1q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1   <= '0;
            r_p2   <= '0;
            r_qhat <= '0;
            r_r    <= '0;
            r_red  <= '0;
            for (int i = 0; i < PAD; i++)
                r_dly[i] <= '0;
        end else begin
            r_p1   <= PW'(i_a) * PW'(i_b);
            r_p2   <= r_p1;
            r_qhat <= (DATA_W + 1)'((QW'(r_p1) * QW'(i_modulus_inv)) >> PW);
            r_r    <= w_r;
            r_red  <= w_red;
            r_dly[0] <= r_red;
            for (int i = 1; i < PAD; i++)
                r_dly[i] <= r_dly[i-1];
        end
    end

    assign o_p = r_dly[PAD-1];

endmodule

// File: rtl/ntt_butterfly_14.sv
// ntt_butterfly_14
// Fully pipelined mod-12289 butterfly, CT or GS per operation, latency 15,
// throughput one per cycle, results in order with the tag echoed.
//   clk, rst : clock, async active-low reset
//   bus      : ntt_butterfly_14_if slave (operands in, results/busy out)
module ntt_butterfly_14
    import ntt_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    ntt_butterfly_14_if.slave  bus
);
    logic              r_s0_valid;
    logic              r_s0_mode;
    logic [DATA_W-1:0] r_s0_side;
    logic [DATA_W-1:0] r_s0_mop;
    logic [DATA_W-1:0] r_s0_w;
    logic [TAG_W-1:0]  r_s0_tag;

    logic [MULT_LAT-1:0] r_dly_valid;
    logic [MULT_LAT-1:0] r_dly_mode;
    logic [DATA_W-1:0]   r_dly_side [MULT_LAT];
    logic [TAG_W-1:0]    r_dly_tag  [MULT_LAT];

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_x;
    logic [DATA_W-1:0] r_out_y;
    logic [TAG_W-1:0]  r_out_tag;

    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_side;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-1:0] w_y;

    // Stage 0: CT multiplies b and carries a; GS folds the sum into the side
    // path and multiplies the difference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0_valid <= 1'b0;
            r_s0_mode  <= 1'b0;
            r_s0_side  <= '0;
            r_s0_mop   <= '0;
            r_s0_w     <= '0;
            r_s0_tag   <= '0;
        end else begin
            r_s0_valid <= bus.in_valid;
            r_s0_mode  <= bus.in_mode;
            r_s0_w     <= bus.in_w;
            r_s0_tag   <= bus.in_tag;
            if (mode_e'(bus.in_mode) == MODE_GS) begin
                r_s0_side <= mod_add(bus.in_a, bus.in_b);
                r_s0_mop  <= mod_sub(bus.in_a, bus.in_b);
            end else begin
                r_s0_side <= bus.in_a;
                r_s0_mop  <= bus.in_b;
            end
        end
    end

    mod_mult_m_14 u_mult (
        .clk           (clk),
        .rst           (rst),
        .i_a           (r_s0_mop),
        .i_b           (r_s0_w),
        .i_modulus     (Q),
        .i_modulus_inv (Q_INV),
        .o_p           (w_prod)
    );

    // Sideband delay matched to the multiplier latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dly_valid <= '0;
            r_dly_mode  <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                r_dly_side[i] <= '0;
                r_dly_tag[i]  <= '0;
            end
        end else begin
            r_dly_valid   <= {r_dly_valid[MULT_LAT-2:0], r_s0_valid};
            r_dly_mode    <= {r_dly_mode[MULT_LAT-2:0], r_s0_mode};
            r_dly_side[0] <= r_s0_side;
            r_dly_tag[0]  <= r_s0_tag;
            for (int i = 1; i < MULT_LAT; i++) begin
                r_dly_side[i] <= r_dly_side[i-1];
                r_dly_tag[i]  <= r_dly_tag[i-1];
            end
        end
    end

    assign w_side = r_dly_side[MULT_LAT-1];

    always_comb begin
        w_x = w_side;
        w_y = w_prod;
        if (mode_e'(r_dly_mode[MULT_LAT-1]) == MODE_CT) begin
            w_x = mod_add(w_side, w_prod);
            w_y = mod_sub(w_side, w_prod);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_tag   <= '0;
        end else begin
            r_out_valid <= r_dly_valid[MULT_LAT-1];
            if (r_dly_valid[MULT_LAT-1]) begin
                r_out_x   <= w_x;
                r_out_y   <= w_y;
                r_out_tag <= r_dly_tag[MULT_LAT-1];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.out_tag   = r_out_tag;
    // The output register is not counted: busy drops as the last result lands.
    assign bus.busy      = r_s0_valid | (|r_dly_valid);

endmodule

// File: tb/tb_ntt_butterfly_14.sv
// tb_ntt_butterfly_14
// Directed and seeded-random stimulus against ntt_butterfly_14 with an
// in-order scoreboard that also checks arrival cycle and output hold.
module tb_ntt_butterfly_14;
    localparam int TAG_W = 8;
    localparam int QI    = 12289;
    localparam int LAT   = 16;   // set_in time to the negedge that shows the result

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ntt_butterfly_14_if #(.TAG_W(TAG_W)) bus ();

    ntt_butterfly_14 #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int x;
        int y;
        int tag;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   pulses = 0;
    int   last_x = 0, last_y = 0, last_tag = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model(input bit m, input int a, input int b, input int w,
                                  output int x, output int y);
        int t;
        if (!m) begin
            t = (w * b) % QI;
            x = (a + t) % QI;
            y = (a - t + QI) % QI;
        end else begin
            x = (a + b) % QI;
            y = (((a - b + QI) % QI) * w) % QI;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input bit m, input int a, input int b, input int w,
                          input int tg, input int ex, input int ey);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.in_a     = 14'(a);
        bus.in_b     = 14'(b);
        bus.in_w     = 14'(w);
        bus.in_tag   = 8'(tg);
        if (v) sb.push_back('{ex, ey, tg, cyc + LAT});
    endtask

    task automatic set_idle();
        set_in(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, QI - 1),
               $urandom_range(0, QI - 1), $urandom_range(0, QI - 1),
               $urandom_range(0, 255), 0, 0);
    endtask

    task automatic set_rand(input bit m, input int tg);
        int a, b, w, x, y;
        a = $urandom_range(0, QI - 1);
        b = $urandom_range(0, QI - 1);
        w = $urandom_range(0, QI - 1);
        model(m, a, b, w, x, y);
        set_in(1'b1, m, a, b, w, tg, x, y);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("rst_out_valid", int'(bus.out_valid), 0);
            check_eq("rst_out_x", int'(bus.out_x), 0);
            check_eq("rst_out_y", int'(bus.out_y), 0);
            check_eq("rst_out_tag", int'(bus.out_tag), 0);
            check_eq("rst_busy", int'(bus.busy), 0);
            last_x = 0; last_y = 0; last_tag = 0;
        end else if (bus.out_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                check_eq("spurious_out_valid", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                check_eq("out_x", int'(bus.out_x), e_mon.x);
                check_eq("out_y", int'(bus.out_y), e_mon.y);
                check_eq("out_tag", int'(bus.out_tag), e_mon.tag);
                check_eq("latency_cycle", cyc, e_mon.cyc);
                last_x = e_mon.x; last_y = e_mon.y; last_tag = e_mon.tag;
            end
        end else begin
            check_eq("hold_x", int'(bus.out_x), last_x);
            check_eq("hold_y", int'(bus.out_y), last_y);
            check_eq("hold_tag", int'(bus.out_tag), last_tag);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int  c_last;
        bit  pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        set_in(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // directed vectors; the first is sampled on the first edge after release
        rst = 1'b1;
        set_in(1'b1, 1'b0, 100, 2, 3, 8'h11, 106, 94);
        step(); set_in(1'b1, 1'b0, 12288, 1, 12288, 8'h22, 12287, 0);
        step(); set_in(1'b1, 1'b1, 5, 10, 2, 8'h33, 15, 12279);
        step(); set_idle();
        repeat (20) begin step(); set_idle(); end

        // back-to-back random, alternating mode
        pulses = 0;
        c_last = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            set_rand(1'(i), 8'h40 + i);
            c_last = cyc;
        end
        step(); set_idle();
        do @(negedge clk); while (cyc < c_last + 15);
        check_eq("busy_before_drain", int'(bus.busy), 1);
        @(negedge clk);
        check_eq("busy_after_drain", int'(bus.busy), 0);
        repeat (3) begin step(); set_idle(); end
        check_eq("rand_pulses", pulses, 32);

        // sparse valid pattern
        c_last = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) c_last = cyc;
            if (pat[i]) set_rand(1'(i), 8'hA0 + i);
            else        set_idle();
        end
        step(); set_idle();
        do @(negedge clk); while (cyc < c_last + LAT);
        for (int i = 0; i < 5; i++) begin
            check_eq("vpat_out_valid", int'(bus.out_valid), int'(pat[i]));
            @(negedge clk);
        end
        repeat (5) begin step(); set_idle(); end

        // reset with ten butterflies in flight
        for (int i = 0; i < 10; i++) begin
            step();
            set_rand(1'(i), 8'hC0 + i);
        end
        step(); set_idle();
        repeat (3) step();
        rst = 1'b0;
        sb.delete();
        #1;
        check_eq("async_rst_out_valid", int'(bus.out_valid), 0);
        check_eq("async_rst_out_x", int'(bus.out_x), 0);
        check_eq("async_rst_out_y", int'(bus.out_y), 0);
        check_eq("async_rst_out_tag", int'(bus.out_tag), 0);
        check_eq("async_rst_busy", int'(bus.busy), 0);
        repeat (2) step();
        rst = 1'b1;
        pulses = 0;
        repeat (30) begin step(); set_idle(); end
        check_eq("post_rst_pulses", pulses, 0);

        // pipeline still usable after reset
        step(); set_in(1'b1, 1'b0, 1, 1, 1, 8'hEE, 2, 0);
        repeat (20) begin step(); set_idle(); end
        check_eq("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ntt_butterfly_14.md
NTT_BUTTERFLY_14 -- requirements
Module: ntt_butterfly_14

Interface
REQ-001 Parameter: TAG_W, 8, width of the sideband tag carried alongside each butterfly.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  the in_a, in_b, in_w, in_mode and in_tag operands are valid this cycle; one butterfly accepted per cycle; no backpressure.
REQ-005 in_mode  input  1  0 = Cooley-Tukey (forward), 1 = Gentleman-Sande (inverse).
REQ-006 in_a  input  14  operand a, range 0..Q-1.
REQ-007 in_b  input  14  operand b, range 0..Q-1.
REQ-008 in_w  input  14  twiddle factor, range 0..Q-1.
REQ-009 in_tag  input  TAG_W  opaque sideband (e.g. address), returned unchanged.
REQ-010 out_valid  output  1  out_x, out_y and out_tag hold a new result.
REQ-011 out_x  output  14  first butterfly output, range 0..Q-1.
REQ-012 out_y  output  14  second butterfly output, range 0..Q-1.
REQ-013 out_tag  output  TAG_W  tag of the butterfly now on the outputs.
REQ-014 busy  output  1  at least one valid butterfly in flight (any pipeline valid bit set).

Function
REQ-015 Q = 12289; all arithmetic mod Q.
REQ-016 CT mode: out_x = (a + w*b) mod Q; out_y = (a - w*b) mod Q.
REQ-017 GS mode: out_x = (a + b) mod Q; out_y = ((a - b) mod Q) * w mod Q.
REQ-018 Stage 0, registered at the sampling edge k: CT passes b to the multiplier operand and a to the side path; GS computes (a+b) mod Q into the side path and (a-b) mod Q into the multiplier operand.
REQ-019 Modular add: 15-bit sum; subtract Q once if sum >= Q. Modular subtract: add Q if a < b.
REQ-020 Stages 1-14: one mod_mult_m_14 instance with fixed latency 14; the side value, mode, tag and valid travel in matched 14-deep delay registers.
REQ-021 Stage 15, the post stage: CT computes side +/- product mod Q; GS passes the side value to x and the product to y.
REQ-022 Latency: an input sampled at edge k appears on the outputs after edge k+15, with out_valid high for exactly one cycle per accepted input.
REQ-023 Throughput: 1 per cycle. Arbitrary valid patterns are reproduced exactly on out_valid, delayed 15 cycles. Results stay in order.
REQ-024 out_x, out_y and out_tag load only when the post-stage valid is set; otherwise they hold their previous values.
REQ-025 Mode is per-butterfly. Mixed CT/GS streams need no bubbles.
REQ-026 Inputs while in_valid = 0 are ignored; the multiplier may compute garbage on them, but it never reaches the outputs.

Reset
REQ-027 While rst = 0: all valid bits are 0; out_valid = 0, out_x = 0, out_y = 0, out_tag = 0, busy = 0.
REQ-028 Reset mid-operation discards all in-flight butterflies; no out_valid follows for inputs accepted before reset.
REQ-029 The first input is accepted on the first rising edge after rst deasserts.

Structure
REQ-030 The shared package ntt_pkg holds Q = 12289, Q_INV = 21843 (15-bit), the data width 14 and the mode encodings. These constants drive the multiplier's modulus and modulus_inv ports.
REQ-031 The one sub-module is mod_mult_m_14. The delay lines and the add/sub logic are local to ntt_butterfly_14.

Verification
REQ-032 CT: a=100, b=2, w=3 -> after 15 cycles out_x=106, out_y=94, out_valid high for one cycle, tag echoed.
REQ-033 CT wrap: a=12288, b=1, w=12288 -> out_x=12287, out_y=0.
REQ-034 GS: a=5, b=10, w=2 -> out_x=15, out_y=12279.
REQ-035 32 back-to-back random vectors with alternating mode -> all match the golden model, tags in order, 32 out_valid pulses, busy falls 15 cycles after the last input.
REQ-036 Valid pattern 1,0,1,1,0 -> identical out_valid pattern 15 cycles later; outputs hold during the bubbles.
REQ-037 rst asserted with 10 butterflies in flight -> outputs immediately 0, busy 0, no out_valid after release until new inputs arrive.
